// File: rtl/eth_rx_fcs_check.sv
// eth_rx_fcs_check
//   Receive-side 802.3 frame check. Runs CRC32 over every received byte,
//   including the FCS, and compares the final register against the fixed
//   residue. Payload is forwarded through a 4-byte delay line, so the FCS
//   bytes are never emitted. Per-frame status is reported at end of frame.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   rx_d        received byte (first byte after SFD first)
//   rx_dv       frame valid, contiguous over a frame
//   rx_er       PHY error, only looked at while rx_dv=1
//   out_d       forwarded payload byte (held when not valid)
//   out_valid   pulse: out_d carries a payload byte
//   out_sof     pulse: out_d is the first payload byte of the frame
//   frame_done  pulse: status outputs were updated this cycle
//   fcs_ok      CRC residue matched and frame had at least 4 bytes (held)
//   len_err     frame_len outside [MIN_LEN, MAX_LEN] (held)
//   phy_err     rx_er seen during the frame (held)
//   frame_len   byte count incl. FCS, saturating at 16'hFFFF (held)

module eth_rx_fcs_check #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_d,
    input  logic        rx_dv,
    input  logic        rx_er,
    output logic [7:0]  out_d,
    output logic        out_valid,
    output logic        out_sof,
    output logic        frame_done,
    output logic        fcs_ok,
    output logic        len_err,
    output logic        phy_err,
    output logic [15:0] frame_len
);

    typedef enum logic [1:0] {SYNC, IDLE, RECV} state_t;

    localparam logic [31:0] CRC_SEED = 32'hFFFF_FFFF;
    // Reflected (LSB-first) form of the 802.3 good-frame residue 0xC704DD7B.
    localparam logic [31:0] RESIDUE  = 32'hDEBB_20E3;
    localparam logic [15:0] MIN_L    = 16'(MIN_LEN);
    localparam logic [15:0] MAX_L    = 16'(MAX_LEN);

    state_t      state_reg, state_next;
    logic [31:0] crc_reg;
    logic [15:0] len_reg;
    logic        perr_reg;
    logic [2:0]  fill_reg;
    logic [7:0]  dly_reg [0:3];

    logic        capture;
    logic        first;
    logic        eof;
    logic [31:0] crc_next;
    logic [15:0] len_next;

    // Reflected byte update: same polynomial and bit order as the transmit
    // generator, LSB of each byte enters first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= SYNC;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        first      = 1'b0;
        eof        = 1'b0;
        case (state_reg)
            // Wait for a gap so a frame already underway is never half-checked.
            SYNC: if (!rx_dv) state_next = IDLE;
            IDLE: if (rx_dv) begin
                state_next = RECV;
                capture    = 1'b1;
                first      = 1'b1;
            end
            RECV: if (rx_dv) begin
                capture = 1'b1;
            end else begin
                state_next = IDLE;
                eof        = 1'b1;
            end
            default: state_next = SYNC;
        endcase
    end

    assign crc_next = crc_byte(first ? CRC_SEED : crc_reg, rx_d);
    assign len_next = first ? 16'd1 :
                      ((len_reg == 16'hFFFF) ? len_reg : len_reg + 16'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crc_reg    <= CRC_SEED;
            len_reg    <= 16'h0;
            perr_reg   <= 1'b0;
            fill_reg   <= 3'd0;
            for (int i = 0; i < 4; i++) dly_reg[i] <= 8'h0;
            out_d      <= 8'h0;
            out_valid  <= 1'b0;
            out_sof    <= 1'b0;
            frame_done <= 1'b0;
            fcs_ok     <= 1'b0;
            len_err    <= 1'b0;
            phy_err    <= 1'b0;
            frame_len  <= 16'h0;
        end else begin
            out_valid  <= 1'b0;
            out_sof    <= 1'b0;
            frame_done <= 1'b0;

            if (capture) begin
                crc_reg  <= crc_next;
                len_reg  <= len_next;
                perr_reg <= first ? rx_er : (perr_reg | rx_er);
                dly_reg[0] <= rx_d;
                for (int i = 1; i < 4; i++) dly_reg[i] <= dly_reg[i-1];
                if (fill_reg == 3'd4) begin
                    out_d     <= dly_reg[3];
                    out_valid <= 1'b1;
                    // Line first fills after 4 bytes, so the first emission
                    // happens while the 5th byte (len_reg==4) is captured.
                    out_sof   <= (len_reg == 16'd4);
                end else begin
                    fill_reg <= fill_reg + 3'd1;
                end
            end

            if (eof) begin
                frame_done <= 1'b1;
                fcs_ok     <= (crc_reg == RESIDUE) && (len_reg >= 16'd4);
                len_err    <= (len_reg < MIN_L) || (len_reg > MAX_L);
                phy_err    <= perr_reg;
                frame_len  <= len_reg;
                // Reseed and drop the FCS bytes still held in the line so a
                // new frame may start on the very next edge.
                crc_reg    <= CRC_SEED;
                fill_reg   <= 3'd0;
            end
        end
    end

endmodule
